// File: rtl/ecc_ram_pkg.sv
// ecc_ram_pkg -- shared definitions for the ECC operand RAM controller.
//   state_e     : controller FSM encoding
//   calc_beats  : host beats per operand word (DATA / HOST_W)
//   beat_cnt_w  : width of a counter that indexes those beats
package ecc_ram_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_COMMIT  = 3'd2,
    RD_FETCH   = 3'd3,
    RD_STREAM  = 3'd4,
    CORE       = 3'd5
  } state_e;

  function automatic int calc_beats(input int data_w, input int host_w);
    return data_w / host_w;
  endfunction

  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ecc_dp_ram.sv
// ecc_dp_ram -- true dual-port operand RAM, synchronous read, no reset.
//   clk                              : single clock
//   a_en_i/a_we_i/a_addr_i/a_din_i   : port A (controller) enable, write, address, data
//   a_dout_o                         : port A read data, one cycle after address
//   b_en_i/b_we_i/b_addr_i/b_din_i   : port B (core) enable, write, address, data
//   b_dout_o                         : port B read data, one cycle after address
// Both ports read the old contents on a same-address write (read-first).
// The controller guarantees the two ports never write in the same cycle,
// so both write paths can share one process.
module ecc_dp_ram #(
  parameter int DATA = 256,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            a_en_i,
  input  logic            a_we_i,
  input  logic [ADDR-1:0] a_addr_i,
  input  logic [DATA-1:0] a_din_i,
  output logic [DATA-1:0] a_dout_o,
  input  logic            b_en_i,
  input  logic            b_we_i,
  input  logic [ADDR-1:0] b_addr_i,
  input  logic [DATA-1:0] b_din_i,
  output logic [DATA-1:0] b_dout_o
);

  logic [DATA-1:0] mem_q [2**ADDR];

  always_ff @(posedge clk) begin
    if (a_en_i) begin
      if (a_we_i) mem_q[a_addr_i] <= a_din_i;
      a_dout_o <= mem_q[a_addr_i];
    end
    if (b_en_i) begin
      if (b_we_i) mem_q[b_addr_i] <= b_din_i;
      b_dout_o <= mem_q[b_addr_i];
    end
  end

endmodule

// File: rtl/ecc_operand_ram_ctrl.sv
// ecc_operand_ram_ctrl -- arbitrates an operand RAM between a narrow host
// bus and a wide ECC core.
//   clk, rst                         : clock, async active-high reset
//   h_wr_valid/h_wr_ready, h_addr,
//   h_wdata                          : host write beats, LS beat first
//   h_rd_req/h_rd_ack                : host read request / acceptance pulse
//   h_rd_valid/h_rd_ready/h_rdata    : host read beat stream, LS beat first
//   start, core_done, owner, done_irq: RAM ownership hand-off to/from core
//   b_w, b_adbus, b_data_in,
//   b_data_out                       : core port (writes honoured only in CORE)
//   err, err_clr                     : sticky protocol error and its clear
module ecc_operand_ram_ctrl
  import ecc_ram_pkg::*;
#(
  parameter int DATA   = 256,
  parameter int ADDR   = 6,
  parameter int HOST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_wr_valid,
  output logic              h_wr_ready,
  input  logic [ADDR-1:0]   h_addr,
  input  logic [HOST_W-1:0] h_wdata,
  input  logic              h_rd_req,
  output logic              h_rd_ack,
  output logic              h_rd_valid,
  input  logic              h_rd_ready,
  output logic [HOST_W-1:0] h_rdata,
  input  logic              start,
  input  logic              core_done,
  output logic              owner,
  output logic              done_irq,
  input  logic              b_w,
  input  logic [ADDR-1:0]   b_adbus,
  input  logic [DATA-1:0]   b_data_in,
  output logic [DATA-1:0]   b_data_out,
  output logic              err,
  input  logic              err_clr
);

  localparam int            BEATS = calc_beats(DATA, HOST_W);
  localparam int            CW    = beat_cnt_w(BEATS);
  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

  if (((DATA % HOST_W) != 0) || (BEATS < 2)) begin : g_bad_cfg
    $error("ecc_operand_ram_ctrl: DATA must be an integer multiple (>=2) of HOST_W");
  end

  state_e            state_q, state_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [DATA-1:0]   asm_q, asm_d;
  logic [DATA-1:0]   shift_q, shift_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic              owner_q, owner_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;

  logic              a_en, a_we;
  logic [ADDR-1:0]   a_addr;
  logic [DATA-1:0]   a_dout;
  logic              b_we;
  logic              wr_ready, rd_ack, rd_valid, err_set;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    asm_d    = asm_q;
    shift_d  = shift_q;
    beat_d   = beat_q;
    a_we     = 1'b0;
    // The read address goes straight to the RAM in the acceptance cycle so
    // the word is ready in RD_FETCH; that is what gives the 2-cycle
    // ack-to-first-beat latency.
    a_addr   = h_addr;
    wr_ready = 1'b0;
    rd_ack   = 1'b0;
    rd_valid = 1'b0;

    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        // Host write beats host read beats core start; a start that loses
        // the arbitration is not retried.
        if (h_wr_valid) begin
          asm_d[HOST_W-1:0] = h_wdata;
          addr_d            = h_addr;
          beat_d            = CW'(1);
          state_d           = WR_COLLECT;
        end else if (h_rd_req) begin
          rd_ack  = 1'b1;
          addr_d  = h_addr;
          state_d = RD_FETCH;
        end else if (start) begin
          state_d = CORE;
        end
      end
      WR_COLLECT: begin
        wr_ready = 1'b1;
        if (h_wr_valid) begin
          asm_d[int'(beat_q)*HOST_W +: HOST_W] = h_wdata;
          if (beat_q == LAST) begin
            beat_d  = '0;
            state_d = WR_COMMIT;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      WR_COMMIT: begin
        a_we    = 1'b1;
        a_addr  = addr_q;
        state_d = IDLE;
      end
      RD_FETCH: begin
        shift_d = a_dout;
        beat_d  = '0;
        state_d = RD_STREAM;
      end
      RD_STREAM: begin
        rd_valid = 1'b1;
        if (h_rd_ready) begin
          shift_d = shift_q >> HOST_W;
          if (beat_q == LAST) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      CORE: begin
        if (core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Offending requests are simply never acted on by the case above;
    // here they only raise the sticky flag, which wins over a clear.
    err_set = (start && (state_q != IDLE)) ||
              ((h_wr_valid || h_rd_req) && (state_q == CORE)) ||
              (core_done && (state_q != CORE));
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;

    owner_d = (state_d == CORE);
    irq_d   = (state_q == CORE) && core_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      asm_q   <= '0;
      shift_q <= '0;
      beat_q  <= '0;
      owner_q <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  // The host port is idle while the core owns the RAM and core writes only
  // land in CORE, so the two sides never touch the array in the same cycle.
  // Core reads stay live at all times so b_data_out always tracks b_adbus.
  assign a_en = (state_q != CORE);
  assign b_we = b_w && (state_q == CORE);

  ecc_dp_ram #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .clk      (clk),
    .a_en_i   (a_en),
    .a_we_i   (a_we),
    .a_addr_i (a_addr),
    .a_din_i  (asm_q),
    .a_dout_o (a_dout),
    .b_en_i   (1'b1),
    .b_we_i   (b_we),
    .b_addr_i (b_adbus),
    .b_din_i  (b_data_in),
    .b_dout_o (b_data_out)
  );

  assign h_wr_ready = wr_ready;
  assign h_rd_ack   = rd_ack && !rst;
  assign h_rd_valid = rd_valid;
  assign h_rdata    = shift_q[HOST_W-1:0];
  assign owner      = owner_q;
  assign done_irq   = irq_q;
  assign err        = err_q;

endmodule
